usb_tx_encoder: RTL

//  USB full-speed transmit encoder, directly downstream of the TX data buffer.

---
 rtl/usb_tx_encoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit encoder.
//   Serialises SYNC, PID, payload bytes popped from the TX data buffer,
//   optional CRC16 and EOP. It applies bit stuffing and NRZI, and drives D+/D-.
//   The protocol controller picks the packet type; this block owns line timing.
// Optional feature: define USB_TX_CRC16_EN to append the CRC16 field to data
//   packets. Without it, data packets go straight from payload to EOP.
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   tx_packet[2:0]       0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 illegal
//   buffer_occupancy[6:0] bytes held in the TX data buffer
//   tx_packet_data[7:0]  popped byte, valid the cycle after the pop strobe
//   get_tx_packet_data   single-cycle pop strobe to the TX data buffer
//   tx_transfer_active   high from accept through the end of EOP
//   tx_error             single-cycle pulse on a rejected request
//   dplus_out, dminus_out USB line drivers
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [6:0]    MAX_CNT   = 7'(MAX_PAYLOAD);
  localparam logic [15:0]   SYNC_WORD = 16'h0080;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [3:0]      r_bit_idx;
  logic [15:0]     r_shift;
  logic [2:0]      r_ones;
  logic            r_stuff;
  logic            r_line;
  logic [6:0]      r_bytes_left;
  logic            r_have_byte;
  logic            r_pop_d;
  logic [7:0]      r_next_byte;
  logic [7:0]      r_pid;
  logic            r_is_data;
  logic            r_error;

  logic            w_accept, w_is_data_req, w_bit_end, w_serial, w_cur_bit;
  logic            w_do_stuff, w_field_last, w_field_done, w_pop, w_next_bit;
  logic [6:0]      w_count;
  logic [15:0]     w_load;

  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    case (code)
      3'd1:    return 8'hC3;
      3'd2:    return 8'h4B;
      3'd3:    return 8'hD2;
      3'd4:    return 8'h5A;
      3'd5:    return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

`ifdef USB_TX_CRC16_EN
  // Reflected form of poly 0x8005, matching the LSB-first bit order on the wire.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 16'hA001 : 16'h0000);
  endfunction

  logic [15:0] r_crc, w_crc_next;
  assign w_crc_next = (r_state == S_DATA && !r_stuff) ? crc16_step(r_crc, w_cur_bit) : r_crc;
`endif

  assign w_is_data_req = (tx_packet == 3'd1) || (tx_packet == 3'd2);
  assign w_accept      = (r_state == S_IDLE) && (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
  assign w_count       = (buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy;
  assign w_bit_end     = (r_clk_cnt == LAST_CLK);
  assign w_serial      = (r_state == S_SYNC) || (r_state == S_PID) ||
                         (r_state == S_DATA) || (r_state == S_CRC);
  // A stuffed bit is always 0; the index keeps pointing at the bit before it.
  assign w_cur_bit     = !r_stuff && r_shift[r_bit_idx];
  assign w_do_stuff    = w_serial && w_cur_bit && (r_ones == 3'd5);
  assign w_field_last  = (r_state == S_CRC) ? (r_bit_idx == 4'd15) : (r_bit_idx == 4'd7);
  assign w_field_done  = w_serial && w_bit_end && !w_do_stuff && w_field_last;
  // Fetch the next byte early in bit 7 so it has arrived by the byte boundary.
  assign w_pop         = ((r_state == S_PID) || (r_state == S_DATA)) && r_is_data &&
                         (r_bytes_left != 7'd0) && (r_bit_idx == 4'd7) && !r_stuff &&
                         (r_clk_cnt == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:        if (w_accept) w_next_state = S_SYNC;
      S_SYNC:        if (w_field_done) w_next_state = S_PID;
      S_PID, S_DATA: if (w_field_done) begin
        if (r_have_byte)    w_next_state = S_DATA;
`ifdef USB_TX_CRC16_EN
        else if (r_is_data) w_next_state = S_CRC;
`endif
        else                w_next_state = S_EOP_SE0;
      end
      S_CRC:         if (w_field_done) w_next_state = S_EOP_SE0;
      S_EOP_SE0:     if (w_bit_end && (r_bit_idx == 4'd1)) w_next_state = S_EOP_J;
      S_EOP_J:       if (w_bit_end) w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  // Contents of the next field, loaded into the shift register at a field boundary.
  always_comb begin
    w_load = 16'h0000;
    case (w_next_state)
      S_PID:   w_load = {8'h00, r_pid};
      S_DATA:  w_load = {8'h00, r_next_byte};
`ifdef USB_TX_CRC16_EN
      S_CRC:   w_load = ~w_crc_next;
`endif
      default: w_load = 16'h0000;
    endcase
  end

  assign w_next_bit = w_do_stuff ? 1'b0 :
                      (w_field_last ? w_load[0] : r_shift[r_bit_idx + 4'd1]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---- bit timing, stuffing and NRZI line state ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= 4'd0;
      r_ones       <= 3'd0;
      r_stuff      <= 1'b0;
      r_line       <= 1'b1;
      r_bytes_left <= 7'd0;
      r_have_byte  <= 1'b0;
      r_pop_d      <= 1'b0;
      r_pid        <= 8'h00;
      r_is_data    <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_error <= (r_state == S_IDLE) && (tx_packet[2:1] == 2'b11);
      r_pop_d <= w_pop;
      if (r_state == S_IDLE) begin
        r_clk_cnt <= '0;
        if (w_accept) begin
          r_bit_idx    <= 4'd0;
          r_ones       <= 3'd0;
          r_stuff      <= 1'b0;
          r_pid        <= pid_byte(tx_packet);
          r_is_data    <= w_is_data_req;
          r_bytes_left <= w_is_data_req ? w_count : 7'd0;
          r_have_byte  <= 1'b0;
          r_line       <= 1'b0;  // SYNC bit 0 is a 0, so the first bit time is K
        end
      end else begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
        if (w_bit_end && w_serial) begin
          r_ones  <= w_cur_bit ? r_ones + 3'd1 : 3'd0;
          r_stuff <= w_do_stuff;
          if (!w_next_bit) r_line <= ~r_line;
          if (!w_do_stuff) begin
            if (w_field_last) begin
              r_bit_idx   <= 4'd0;
              r_have_byte <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
          // NRZI restarts from J so the EOP tail and the next packet begin from idle.
          if (w_next_state == S_EOP_SE0) r_line <= 1'b1;
        end else if (w_bit_end) begin
          r_bit_idx <= ((r_state == S_EOP_SE0) && (r_bit_idx == 4'd0)) ? 4'd1 : 4'd0;
        end
        if (w_pop) begin
          r_bytes_left <= r_bytes_left - 7'd1;
          r_have_byte  <= 1'b1;
        end
      end
    end
  end

  // ---- data path: shift register, popped byte, CRC ----
  always_ff @(posedge clk) begin
    if (r_pop_d) r_next_byte <= tx_packet_data;
    if (r_state == S_IDLE)  r_shift <= SYNC_WORD;
    else if (w_field_done)  r_shift <= w_load;
`ifdef USB_TX_CRC16_EN
    if (w_accept)       r_crc <= 16'hFFFF;
    else if (w_bit_end) r_crc <= w_crc_next;
`endif
  end

  assign get_tx_packet_data = w_pop;
  assign tx_transfer_active = (r_state != S_IDLE);
  assign tx_error           = r_error;
  assign dplus_out          = (r_state == S_EOP_SE0) ? 1'b0 : r_line;
  assign dminus_out         = (r_state == S_EOP_SE0) ? 1'b0 : ~r_line;

endmodule
